// File: rtl/board_input_conditioner_if.sv
// rtl/board_input_conditioner_if.sv - raw board inputs and conditioned processor-facing outputs
interface board_input_conditioner_if;
  logic [4:0]  in0_switches;
  logic [4:0]  in1_switches;
  logic [3:0]  buttons;
  logic [31:0] proc_in0;
  logic [31:0] proc_in1;
  logic [31:0] proc_in2;
  logic [3:0]  btn_press;

  modport master (
    output in0_switches, in1_switches, buttons,
    input  proc_in0, proc_in1, proc_in2, btn_press
  );

  modport slave (
    input  in0_switches, in1_switches, buttons,
    output proc_in0, proc_in1, proc_in2, btn_press
  );
endinterface

// File: rtl/board_input_conditioner.sv
// rtl/board_input_conditioner.sv - synchronise and debounce 14 board input bits, emit button press pulses
module board_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  board_input_conditioner_if.slave   bus
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int NCH   = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel layout: [4:0] bank 0, [9:5] bank 1, [13:10] buttons.
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync_q [SYNC_STAGES];
  logic [NCH-1:0]   sync_val;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W-1:0] cnt_d  [NCH];
  logic [3:0]       press_q;

  assign raw      = {bus.buttons, bus.in1_switches, bus.in0_switches};
  assign sync_val = sync_q[SYNC_STAGES-1];

  always_comb begin
    stable_d = stable_q;
    for (int ch = 0; ch < NCH; ch++) begin
      cnt_d[ch] = '0;
      if (sync_val[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CNT_MAX)
          stable_d[ch] = sync_val[ch];
        else
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      for (int ch = 0; ch < NCH; ch++)
        cnt_q[ch] <= '0;
      stable_q <= '0;
      press_q  <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_q[s-1];
      for (int ch = 0; ch < NCH; ch++)
        cnt_q[ch] <= cnt_d[ch];
      stable_q <= stable_d;
      // Pulse on the same edge the debounced button rises; drops the following edge.
      press_q  <= stable_d[13:10] & ~stable_q[13:10];
    end
  end

  assign bus.proc_in0  = {27'b0, stable_q[4:0]};
  assign bus.proc_in1  = {27'b0, stable_q[9:5]};
  assign bus.proc_in2  = {28'b0, stable_q[13:10]};
  assign bus.btn_press = press_q;
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb/tb_board_input_conditioner.sv - directed checks of sync/debounce latency, glitches, presses and reset
module tb_board_input_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  board_input_conditioner_if bus ();

  board_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [3:0] ep);
    check({tag, "_in0"}, bus.proc_in0, e0);
    check({tag, "_in1"}, bus.proc_in1, e1);
    check({tag, "_in2"}, bus.proc_in2, e2);
    check({tag, "_press"}, {28'b0, bus.btn_press}, {28'b0, ep});
  endtask

  initial begin
    bus.in0_switches = '0;
    bus.in1_switches = '0;
    bus.buttons      = '0;
    tick();
    tick();
    check_outs("reset", 32'h0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;

    // Idle: everything stays zero
    for (int i = 0; i < 50; i++) begin
      tick();
      check_outs("idle", 32'h0, 32'h0, 32'h0, 4'h0);
    end

    // Switch bank 0 latency: accepted on edge 18
    bus.in0_switches = 5'b10110;
    for (int e = 1; e <= 18; e++) begin
      tick();
      check("sw_lat_in0", bus.proc_in0, (e >= 18) ? 32'h16 : 32'h0);
    end
    check("sw_lat_in1", bus.proc_in1, 32'h0);
    check("sw_lat_in2", bus.proc_in2, 32'h0);

    // Short glitch on buttons[2] never reaches the outputs
    bus.buttons = 4'b0100;
    for (int e = 1; e <= 40; e++) begin
      if (e == 11) bus.buttons = 4'b0000;
      tick();
      check("glitch_in2", bus.proc_in2, 32'h0);
      check("glitch_press", {28'b0, bus.btn_press}, 32'h0);
    end

    // Two buttons pressed together, held 40 cycles
    bus.buttons = 4'b1001;
    for (int e = 1; e <= 40; e++) begin
      tick();
      check("press_in2", bus.proc_in2, (e >= 18) ? 32'h9 : 32'h0);
      check("press_pulse", {28'b0, bus.btn_press}, (e == 18) ? 32'h9 : 32'h0);
    end
    check("press_in0_kept", bus.proc_in0, 32'h16);

    // Release: same latency, no pulse
    bus.buttons = 4'b0000;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check("release_in2", bus.proc_in2, (e >= 18) ? 32'h0 : 32'h9);
      check("release_pulse", {28'b0, bus.btn_press}, 32'h0);
    end

    // Bounce on buttons[0]: 8 high, 3 low, 20 high; last rise set after edge 11 -> accept edge 29
    bus.buttons = 4'b0001;
    for (int e = 1; e <= 31; e++) begin
      tick();
      if (e == 8)  bus.buttons = 4'b0000;
      if (e == 11) bus.buttons = 4'b0001;
      check("bounce_in2", bus.proc_in2, (e >= 29) ? 32'h1 : 32'h0);
      check("bounce_pulse", {28'b0, bus.btn_press}, (e == 29) ? 32'h1 : 32'h0);
    end
    bus.buttons = 4'b0000;
    for (int e = 1; e <= 20; e++) tick();
    check("bounce_settle", bus.proc_in2, 32'h0);

    // buttons[1] accepted, then reset while held
    bus.buttons = 4'b0010;
    for (int e = 1; e <= 18; e++) tick();
    check_outs("pre_rst", 32'h16, 32'h0, 32'h2, 4'h2);
    tick();
    check("pre_rst_pulse_end", {28'b0, bus.btn_press}, 32'h0);
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 32'h0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    tick();
    check_outs("in_rst", 32'h0, 32'h0, 32'h0, 4'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      tick();
      check("post_rst_in2", bus.proc_in2, (e >= 18) ? 32'h2 : 32'h0);
      check("post_rst_in0", bus.proc_in0, (e >= 18) ? 32'h16 : 32'h0);
      check("post_rst_pulse", {28'b0, bus.btn_press}, (e == 18) ? 32'h2 : 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
